// File: rtl/uart_word_link.sv
// Word-oriented UART link: 2-FF synchronised receiver that assembles little-endian
// words, and a transmitter that serialises whole words byte0 first.
module uart_word_link #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int BYTES        = 4,
    parameter int TIMEOUT_BITS = 20,
    parameter int ECHO         = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic                 TxD,
    output logic [8*BYTES-1:0]   rx_word,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    input  logic [8*BYTES-1:0]   tx_word,
    input  logic                 tx_start,
    output logic                 tx_busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int W        = 8 * BYTES;
    localparam int CNT_W    = $clog2(BAUD_DIV + 1);
    localparam int IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_LIM   = TIMEOUT_BITS * BAUD_DIV;
    localparam int TO_W     = (TO_LIM > 1) ? $clog2(TO_LIM) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    logic rx_meta_q, rxs_q;

    rx_state_e         rx_st_q, rx_st_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W-1:0]      shadow_q, shadow_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [W-1:0]      rx_word_q, rx_word_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_ferr_q, rx_ferr_d;
    logic [W-1:0]      merged;
    logic              rx_tick;

    tx_state_e         tx_st_q, tx_st_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [IDX_W-1:0]  tx_byte_q, tx_byte_d;
    logic [W-1:0]      tx_sh_q, tx_sh_d;
    logic              txd_q, txd_d;
    logic              tx_tick, tx_last, tx_accept;

    // ---------------- receiver ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            to_q       <= '0;
            rx_word_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= RxD;
            rxs_q      <= rx_meta_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            to_q       <= to_d;
            rx_word_q  <= rx_word_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_tick = (rx_cnt_q == CNT_W'(1));

    always_comb begin
        rx_st_d = rx_st_q;
        case (rx_st_q)
            RX_IDLE:      if (!rxs_q) rx_st_d = RX_START;
            RX_START:     if (rx_tick) rx_st_d = rxs_q ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_tick && rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            RX_STOP:      if (rx_tick) rx_st_d = rxs_q ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rxs_q) rx_st_d = RX_IDLE;
            default:      rx_st_d = RX_IDLE;
        endcase
    end

    always_comb begin
        merged = shadow_q;
        merged[8*idx_q +: 8] = rx_sh_q;
    end

    always_comb begin
        rx_cnt_d   = (rx_cnt_q != '0) ? rx_cnt_q - 1'b1 : '0;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        to_d       = '0;
        rx_word_d  = rx_word_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: if (!rxs_q) rx_cnt_d = CNT_HALF;
            RX_START: if (rx_tick && !rxs_q) begin
                rx_cnt_d = CNT_FULL;
                rx_bit_d = '0;
            end
            RX_DATA: if (rx_tick) begin
                rx_sh_d  = {rxs_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                rx_cnt_d = CNT_FULL;
            end
            RX_STOP: if (rx_tick) begin
                if (rxs_q) begin
                    if (idx_q == IDX_LAST) begin
                        rx_word_d  = merged;
                        rx_valid_d = 1'b1;
                        idx_d      = '0;
                    end else begin
                        shadow_d = merged;
                        idx_d    = idx_q + 1'b1;
                    end
                end else begin
                    rx_ferr_d = 1'b1;
                    idx_d     = '0;
                end
            end
            default: ;
        endcase
        // Partial-word watchdog: only counts while idle mid-word, cleared by a start edge.
        if (TO_LIM != 0 && rx_st_q == RX_IDLE && idx_q != '0 && rxs_q) begin
            if (to_q == TO_W'(TO_LIM - 1)) begin
                idx_d = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // ---------------- transmitter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q   <= TX_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_byte_q <= '0;
            tx_sh_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_byte_q <= tx_byte_d;
            tx_sh_q   <= tx_sh_d;
            txd_q     <= txd_d;
        end
    end

    assign tx_tick   = (tx_cnt_q == CNT_W'(1));
    assign tx_last   = (tx_bit_q == 4'd9) && (tx_byte_q == IDX_LAST);
    assign tx_accept = (tx_st_q == TX_IDLE) && (tx_start || (ECHO != 0 && rx_valid_q));

    always_comb begin
        tx_st_d = tx_st_q;
        case (tx_st_q)
            TX_IDLE: if (tx_accept) tx_st_d = TX_SEND;
            TX_SEND: if (tx_tick && tx_last) tx_st_d = TX_IDLE;
            default: tx_st_d = TX_IDLE;
        endcase
    end

    // Frame bit index: 0 = start, 1..8 = data (LSB first), 9 = stop.
    always_comb begin
        tx_cnt_d  = (tx_cnt_q != '0) ? tx_cnt_q - 1'b1 : '0;
        tx_bit_d  = tx_bit_q;
        tx_byte_d = tx_byte_q;
        tx_sh_d   = tx_sh_q;
        txd_d     = txd_q;
        case (tx_st_q)
            TX_IDLE: if (tx_accept) begin
                tx_sh_d   = tx_word;
                txd_d     = 1'b0;
                tx_cnt_d  = CNT_FULL;
                tx_bit_d  = '0;
                tx_byte_d = '0;
            end
            TX_SEND: if (tx_tick) begin
                tx_cnt_d = CNT_FULL;
                if (tx_bit_q == 4'd9) begin
                    if (tx_last) begin
                        txd_d = 1'b1;
                    end else begin
                        tx_byte_d = tx_byte_q + 1'b1;
                        tx_bit_d  = '0;
                        txd_d     = 1'b0;
                    end
                end else if (tx_bit_q == 4'd8) begin
                    tx_bit_d = 4'd9;
                    txd_d    = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                end
            end
            default: ;
        endcase
    end

    assign TxD          = txd_q;
    assign tx_busy      = (tx_st_q == TX_SEND);
    assign rx_word      = rx_word_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
endmodule
